// File: rtl/shared_pkg.sv
`default_nettype none
// ============================================================================
// Module : shared_pkg
// Brief  : Shared types and constants for the FIFO write-port arbiter.
// Rev    : 1.0
// ============================================================================
package shared_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      BLOCK = 2'd2
   } arb_state_e;

   localparam int DROP_CNT_MAX   = 255;
   localparam int DEF_FIFO_WIDTH = 16;

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module : rr_pick
// Brief  : Combinational rotate-priority encoder; search starts after `last`.
// Rev    : 1.0
// ============================================================================
module rr_pick
   import shared_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    last,
   output logic [NUM_REQ-1:0] gnt_onehot,
   output logic [ID_W-1:0]    gnt_id
);

   always_comb begin
      logic            found;
      logic [ID_W-1:0] idx;
      found      = 1'b0;
      idx        = '0;
      gnt_onehot = '0;
      gnt_id     = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = ID_W'((int'(last) + k) % NUM_REQ);
         if (!found && req[idx]) begin
            found           = 1'b1;
            gnt_onehot[idx] = 1'b1;
            gnt_id          = idx;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : fifo_wr_arbiter
// Brief  : Round-robin arbiter sharing one FIFO write port, with ack checking.
// Rev    : 1.0
// ============================================================================
module fifo_wr_arbiter
   import shared_pkg::*;
#(
   parameter  int NUM_REQ    = 4,
   parameter  int FIFO_WIDTH = DEF_FIFO_WIDTH,
   localparam int ID_W       = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   input  logic                          fifo_almostfull,
   input  logic                          fifo_wr_ack,
   input  logic                          fifo_overflow,
   output logic                          wr_en,
   output logic [FIFO_WIDTH-1:0]         data_in,
   output logic [ID_W-1:0]               grant_id,
   output logic                          stall,
   output logic                          ack_err,
   output logic [7:0]                    drop_cnt
);

   arb_state_e              r_state;
   arb_state_e              w_state_nxt;
   logic [ID_W-1:0]         r_last;
   logic [FIFO_WIDTH-1:0]   r_data;
   logic [ID_W-1:0]         r_gid;
   logic                    r_ack_pend;
   logic                    r_ack_err;
   logic [7:0]              r_drop;

   logic                    w_wr_en;
   logic                    w_can_accept;
   logic                    w_any;
   logic                    w_xfer;
   logic [NUM_REQ-1:0]      w_gnt_onehot;
   logic [ID_W-1:0]         w_gnt_id;
   logic [FIFO_WIDTH-1:0]   w_word;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
      .req        (req_valid),
      .last       (r_last),
      .gnt_onehot (w_gnt_onehot),
      .gnt_id     (w_gnt_id)
   );

   assign w_wr_en      = (r_state == WRITE);
   // A write already in flight consumes the last free slot at almostfull.
   assign w_can_accept = !fifo_full && !(fifo_almostfull && w_wr_en);
   assign w_any        = |req_valid;
   assign w_xfer       = w_any && w_can_accept;
   assign req_ready    = w_gnt_onehot & {NUM_REQ{w_can_accept}};
   assign w_word       = req_data[w_gnt_id*FIFO_WIDTH +: FIFO_WIDTH];

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE, WRITE: begin
            if (w_xfer)      w_state_nxt = WRITE;
            else if (w_any)  w_state_nxt = BLOCK;
            else             w_state_nxt = IDLE;
         end
         BLOCK: begin
            if (w_xfer)      w_state_nxt = WRITE;
            else if (!w_any) w_state_nxt = IDLE;
            else             w_state_nxt = BLOCK;
         end
         default:            w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_last     <= ID_W'(NUM_REQ - 1);
         r_data     <= '0;
         r_gid      <= '0;
         r_ack_pend <= 1'b0;
         r_ack_err  <= 1'b0;
         r_drop     <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_ack_pend <= w_wr_en;
         if (w_xfer) begin
            r_last <= w_gnt_id;
            r_data <= w_word;
            r_gid  <= w_gnt_id;
         end
         if (r_ack_pend && (fifo_overflow || !fifo_wr_ack)) begin
            r_ack_err <= 1'b1;
            if (r_drop != 8'(DROP_CNT_MAX)) r_drop <= r_drop + 8'd1;
         end
      end
   end

   assign wr_en    = w_wr_en;
   assign data_in  = r_data;
   assign grant_id = r_gid;
   assign stall    = (r_state == BLOCK);
   assign ack_err  = r_ack_err;
   assign drop_cnt = r_drop;

endmodule
`default_nettype wire
